// File: rtl/ula_sequenciador.sv
// Multi-cycle execute sequencer driving an 8-bit combinational ULA.
// Define ULA_SEQ_MUL_EN to build in the iterative multiply (MUL_LOOP, acc, cnt).
module ula_sequenciador (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    input  logic [2:0] Op,
    input  logic [7:0] OpA,
    input  logic [7:0] OpB,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] Result,
    output logic       Branch,
    output logic [7:0] SrcA,
    output logic [7:0] SrcB,
    output logic [2:0] ULAControl,
    input  logic [7:0] ULAResult,
    input  logic       FlagZ
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_ILL = 3'b100;
    localparam logic [2:0] OP_BNE = 3'b101;
    localparam logic [2:0] OP_BEQ = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
`ifdef ULA_SEQ_MUL_EN
        S_MUL_LOOP = 2'd2,
`endif
        S_EXEC     = 2'd1
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_result;
    logic       r_branch;
    logic       w_accept;
    logic       w_finish;
    logic [7:0] w_result;
    logic       w_branch;
    logic [7:0] w_src_a;
    logic [7:0] w_src_b;
    logic [2:0] w_ula_ctrl;
`ifdef ULA_SEQ_MUL_EN
    logic [7:0] r_acc;
    logic [7:0] r_cnt;
`endif

    // Ops the sequencer completes with a zero result instead of the ULA output
    function automatic logic f_is_illegal(input logic [2:0] op);
`ifdef ULA_SEQ_MUL_EN
        f_is_illegal = (op == OP_ILL);
`else
        f_is_illegal = (op == OP_ILL) || (op == OP_MUL);
`endif
    endfunction

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, ULA drive and completion decode
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        w_result     = 8'h00;
        w_branch     = 1'b0;
        w_src_a      = 8'h00;
        w_src_b      = 8'h00;
        w_ula_ctrl   = OP_ADD;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_accept = 1'b1;
`ifdef ULA_SEQ_MUL_EN
                    if (Op == OP_MUL) begin
                        w_next_state = S_MUL_LOOP;
                    end else begin
                        w_next_state = S_EXEC;
                    end
`else
                    w_next_state = S_EXEC;
`endif
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_EXEC: begin
                w_src_a      = r_a;
                w_src_b      = r_b;
                w_ula_ctrl   = r_op;
                w_finish     = 1'b1;
                w_next_state = S_IDLE;
                if (f_is_illegal(r_op)) begin
                    w_result = 8'h00;
                    w_branch = 1'b0;
                end else if ((r_op == OP_BNE) || (r_op == OP_BEQ)) begin
                    // The ULA raises FlagZ exactly when either branch is taken
                    w_result = ULAResult;
                    w_branch = FlagZ;
                end else begin
                    w_result = ULAResult;
                    w_branch = 1'b0;
                end
            end
`ifdef ULA_SEQ_MUL_EN
            S_MUL_LOOP: begin
                w_src_a    = r_acc;
                w_src_b    = r_a;
                w_ula_ctrl = OP_ADD;
                if (r_cnt == 8'h00) begin
                    w_finish     = 1'b1;
                    w_result     = r_acc;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_MUL_LOOP;
                end
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand latch, handshake flags and registered results
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_op     <= 3'b000;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 8'h00;
            r_branch <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_op   <= Op;
                r_a    <= OpA;
                r_b    <= OpB;
                r_busy <= 1'b1;
            end else if (w_finish) begin
                r_busy   <= 1'b0;
                r_result <= w_result;
                r_branch <= w_branch;
            end
        end
    end

`ifdef ULA_SEQ_MUL_EN
    // Multiply accumulator and iteration counter (counter uses its own decrementer)
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_acc <= 8'h00;
            r_cnt <= 8'h00;
        end else if (w_accept) begin
            r_acc <= 8'h00;
            r_cnt <= OpB;
        end else if ((r_state == S_MUL_LOOP) && (r_cnt != 8'h00)) begin
            r_acc <= ULAResult;
            r_cnt <= r_cnt - 8'd1;
        end
    end
`endif

    assign Busy       = r_busy;
    assign Done       = r_done;
    assign Result     = r_result;
    assign Branch     = r_branch;
    assign SrcA       = w_src_a;
    assign SrcB       = w_src_b;
    assign ULAControl = w_ula_ctrl;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Self-checking bench for ula_sequenciador with a behavioural ULA and reference model.
// Honours ULA_SEQ_MUL_EN the same way as the design.
module tb_ula_sequenciador;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       branch;
    logic [7:0] src_a;
    logic [7:0] src_b;
    logic [2:0] ula_ctrl;
    logic [7:0] ula_result;
    logic       flag_z;

    int n_checks = 0;
    int n_fail   = 0;
    logic prev_done = 1'b0;

    ula_sequenciador dut (
        .Clk(clk), .Rst_n(rst_n), .Start(start), .Op(op), .OpA(op_a), .OpB(op_b),
        .Busy(busy), .Done(done), .Result(result), .Branch(branch),
        .SrcA(src_a), .SrcB(src_b), .ULAControl(ula_ctrl),
        .ULAResult(ula_result), .FlagZ(flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ULA: BEQ/BNE subtract and raise FlagZ when the branch is taken
    always_comb begin
        ula_result = 8'h00;
        flag_z     = 1'b0;
        case (ula_ctrl)
            3'b000:  ula_result = src_a & src_b;
            3'b001:  ula_result = src_a | src_b;
            3'b010:  ula_result = src_a + src_b;
            3'b011:  ula_result = src_a ^ src_b;
            3'b100:  ula_result = 8'hA5;
            3'b101:  ula_result = src_a - src_b;
            3'b110:  ula_result = src_a - src_b;
            default: ula_result = (src_a < src_b) ? 8'd1 : 8'd0;
        endcase
        if (ula_ctrl == 3'b110)      flag_z = (src_a == src_b);
        else if (ula_ctrl == 3'b101) flag_z = (src_a != src_b);
        else                         flag_z = (ula_result == 8'h00);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_result(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b010: return a + b;
`ifdef ULA_SEQ_MUL_EN
            3'b011: return 8'((a * b) % 256);
`else
            3'b011: return 8'h00;
`endif
            3'b101: return a - b;
            3'b110: return a - b;
            3'b111: return (a < b) ? 8'd1 : 8'd0;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic exp_branch(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        if (o == 3'b110) return a == b;
        if (o == 3'b101) return a != b;
        return 1'b0;
    endfunction

    function automatic int exp_busy(input logic [2:0] o, input logic [7:0] b);
`ifdef ULA_SEQ_MUL_EN
        if (o == 3'b011) return int'(b) + 1;
`endif
        return 1;
    endfunction

    // Protocol invariants sampled every cycle out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            check("done_busy_together", {31'd0, done & busy}, 32'd0);
            check("done_adjacent", {31'd0, done & prev_done}, 32'd0);
        end
        prev_done <= done;
    end

    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        int   n;
        int   busy_n;
        logic seen;
        @(negedge clk);
        start = 1'b1; op = o; op_a = a; op_b = b;
        n = 0; busy_n = 0; seen = 1'b0;
        while (!seen && n < 300) begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (busy) busy_n++;
            if (done) seen = 1'b1;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("latency", n, exp_busy(o, b) + 1);
        check("busy_cycles", busy_n, exp_busy(o, b));
        check("result", {24'd0, result}, {24'd0, exp_result(o, a, b)});
        check("branch", {31'd0, branch}, {31'd0, exp_branch(o, a, b)});
        check("busy_at_done", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("result_held", {24'd0, result}, {24'd0, exp_result(o, a, b)});
        check("idle_ula_drive", {16'd0, src_a, src_b}, 32'd0);
        check("idle_ula_ctrl", {29'd0, ula_ctrl}, 32'd2);
    endtask

    initial begin
        logic [7:0] ha [0:11];
        logic [7:0] hb [0:11];
        int         dcount;
        start = 1'b0; op = 3'b000; op_a = 8'h00; op_b = 8'h00;
        rst_n = 1'b0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_branch", {31'd0, branch}, 32'd0);
        check("rst_src", {16'd0, src_a, src_b}, 32'd0);
        check("rst_ctrl", {29'd0, ula_ctrl}, 32'd2);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'b010, 8'hF0, 8'h20);
        run_op(3'b110, 8'h5A, 8'h5A);
        run_op(3'b110, 8'h5A, 8'h5B);
        run_op(3'b101, 8'h5A, 8'h5A);
        run_op(3'b101, 8'h5A, 8'h5B);
        run_op(3'b011, 8'd13, 8'd7);
        run_op(3'b011, 8'h10, 8'h10);
        run_op(3'b011, 8'h37, 8'h00);
        run_op(3'b100, 8'h12, 8'h34);
        run_op(3'b111, 8'h80, 8'h7F);
        run_op(3'b111, 8'h01, 8'hFE);
        run_op(3'b011, 8'hFF, 8'hFF);

        for (int i = 0; i < 30; i++) begin
            logic [2:0] ro;
            logic [7:0] rb;
            ro = 3'($urandom_range(0, 7));
            rb = (ro == 3'b011) ? 8'($urandom_range(0, 40)) : 8'($urandom);
            run_op(ro, 8'($urandom), rb);
        end

        // Start held high: accepted on every second edge, the rest ignored
        for (int i = 0; i < 12; i++) begin
            ha[i] = 8'($urandom);
            hb[i] = 8'($urandom);
        end
        @(negedge clk);
        start = 1'b1; op = 3'b010;
        for (int i = 0; i < 12; i++) begin
            op_a = ha[i]; op_b = hb[i];
            @(posedge clk); #1;
            if (i % 2 == 1) begin
                check("held_done", {31'd0, done}, 32'd1);
                check("held_busy", {31'd0, busy}, 32'd0);
                check("held_result", {24'd0, result}, {24'd0, 8'(ha[i-1] + hb[i-1])});
            end else begin
                check("held_no_done", {31'd0, done}, 32'd0);
                check("held_busy_on", {31'd0, busy}, 32'd1);
            end
            @(negedge clk);
        end
        start = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a long multiply
        run_op(3'b010, 8'h01, 8'h02);
        @(negedge clk);
        start = 1'b1; op = 3'b011; op_a = 8'h03; op_b = 8'd200;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", {24'd0, result}, 32'd0);
        check("abort_branch", {31'd0, branch}, 32'd0);
        check("abort_ctrl", {29'd0, ula_ctrl}, 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 220; i++) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        check("abort_no_done", dcount, 0);
        run_op(3'b010, 8'h33, 8'h44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
